// File: rtl/avm_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package avm_pkg;

  localparam int unsigned MaxBurst = 4;
  localparam int unsigned AddrW    = 30;
  localparam int unsigned DataW    = 32;
  localparam int unsigned BeW      = 4;
  localparam int unsigned BurstW   = $clog2(MaxBurst) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StWrite,
    StReadWait
  } avm_state_e;

  // A zero burstcount is treated as a single beat.
  function automatic logic [BurstW-1:0] burst_len(input logic [BurstW-1:0] bc);
    return (bc == '0) ? BurstW'(1) : bc;
  endfunction

endpackage

// File: rtl/avm_rr_pick.sv
// Two-way requester picker: round-robin or fixed m0 priority, with last-grant register.
module avm_rr_pick
  import avm_pkg::*;
#(
  parameter bit FixedPriority = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       grant_o
);

  logic last_q;

  always_comb begin
    grant_o = 1'b0;
    if (req_i[0] && req_i[1]) begin
      grant_o = FixedPriority ? 1'b0 : ~last_q;
    end else begin
      grant_o = req_i[1];
    end
  end

  // Reset to m1 so that m0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/avm_arbiter.sv
// Two-master Avalon-MM arbiter with a single outstanding transaction on the shared port.
module avm_arbiter
  import avm_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AddrW-1:0]  m0_address_i,
  input  logic [DataW-1:0]  m0_writedata_i,
  input  logic [BeW-1:0]    m0_byteenable_i,
  input  logic [BurstW-1:0] m0_burstcount_i,
  input  logic              m0_write_i,
  input  logic              m0_read_i,
  output logic              m0_waitrequest_o,
  output logic              m0_readdatavalid_o,
  output logic [DataW-1:0]  m0_readdata_o,
  input  logic [AddrW-1:0]  m1_address_i,
  input  logic [DataW-1:0]  m1_writedata_i,
  input  logic [BeW-1:0]    m1_byteenable_i,
  input  logic [BurstW-1:0] m1_burstcount_i,
  input  logic              m1_write_i,
  input  logic              m1_read_i,
  output logic              m1_waitrequest_o,
  output logic              m1_readdatavalid_o,
  output logic [DataW-1:0]  m1_readdata_o,
  output logic [AddrW-1:0]  s_address_o,
  output logic [DataW-1:0]  s_writedata_o,
  output logic [BeW-1:0]    s_byteenable_o,
  output logic [BurstW-1:0] s_burstcount_o,
  output logic              s_write_o,
  output logic              s_read_o,
  input  logic              s_waitrequest_i,
  input  logic              s_readdatavalid_i,
  input  logic [DataW-1:0]  s_readdata_i
);

  avm_state_e        state_q;
  logic              grant_q;
  logic [BurstW-1:0] beats_q;
  logic [BurstW-1:0] count_q;

  logic [1:0]        req;
  logic              pick;
  logic              arb_update;
  logic [AddrW-1:0]  gm_address;
  logic [DataW-1:0]  gm_writedata;
  logic [BeW-1:0]    gm_byteenable;
  logic [BurstW-1:0] gm_burstcount;
  logic              gm_write;
  logic              gm_read;
  logic [BurstW-1:0] count_inc;
  logic              last_beat;
  logic              cmd_phase;
  logic              rd_phase;

  assign req        = {m1_read_i | m1_write_i, m0_read_i | m0_write_i};
  assign arb_update = (state_q == StIdle) && (req != 2'b00);

  avm_rr_pick #(
    .FixedPriority(FIXED_PRIORITY)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .update_i(arb_update),
    .grant_o (pick)
  );

  always_comb begin
    gm_address    = m0_address_i;
    gm_writedata  = m0_writedata_i;
    gm_byteenable = m0_byteenable_i;
    gm_burstcount = m0_burstcount_i;
    gm_write      = m0_write_i;
    gm_read       = m0_read_i;
    if (grant_q) begin
      gm_address    = m1_address_i;
      gm_writedata  = m1_writedata_i;
      gm_byteenable = m1_byteenable_i;
      gm_burstcount = m1_burstcount_i;
      gm_write      = m1_write_i;
      gm_read       = m1_read_i;
    end
  end

  assign count_inc = count_q + BurstW'(1);
  assign last_beat = (count_inc == beats_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      beats_q <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req != 2'b00) begin
            grant_q <= pick;
            beats_q <= burst_len(pick ? m1_burstcount_i : m0_burstcount_i);
            count_q <= '0;
            state_q <= StGrant;
          end
        end
        StGrant, StWrite: begin
          // Write wins when a master raises both strobes.
          if (gm_write) begin
            if (!s_waitrequest_i) begin
              if (last_beat) begin
                count_q <= '0;
                state_q <= StIdle;
              end else begin
                count_q <= count_inc;
                state_q <= StWrite;
              end
            end
          end else if (gm_read && (state_q == StGrant) && !s_waitrequest_i) begin
            count_q <= '0;
            state_q <= StReadWait;
          end
        end
        StReadWait: begin
          if (s_readdatavalid_i) begin
            if (last_beat) begin
              count_q <= '0;
              state_q <= StIdle;
            end else begin
              count_q <= count_inc;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_phase = (state_q == StGrant) || (state_q == StWrite);
  assign rd_phase  = (state_q == StReadWait);

  always_comb begin
    s_address_o    = '0;
    s_writedata_o  = '0;
    s_byteenable_o = '0;
    s_burstcount_o = '0;
    s_write_o      = 1'b0;
    s_read_o       = 1'b0;
    if (cmd_phase) begin
      s_address_o    = gm_address;
      s_writedata_o  = gm_writedata;
      s_byteenable_o = gm_byteenable;
      s_burstcount_o = gm_burstcount;
      s_write_o      = gm_write;
      s_read_o       = (state_q == StGrant) && gm_read && !gm_write;
    end
  end

  assign m0_waitrequest_o   = (cmd_phase && !grant_q) ? s_waitrequest_i : 1'b1;
  assign m1_waitrequest_o   = (cmd_phase && grant_q) ? s_waitrequest_i : 1'b1;
  assign m0_readdatavalid_o = rd_phase && !grant_q && s_readdatavalid_i;
  assign m1_readdatavalid_o = rd_phase && grant_q && s_readdatavalid_i;
  assign m0_readdata_o      = s_readdata_i;
  assign m1_readdata_o      = s_readdata_i;

endmodule

// File: tb/tb_avm_arbiter.sv
// Directed bench for avm_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_avm_arbiter;

  logic        clk;
  logic        rst_n;
  logic [29:0] m0_address, m1_address;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [2:0]  m0_burstcount, m1_burstcount;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic        s_waitrequest, s_readdatavalid;
  logic [31:0] s_readdata;

  logic        rr_m0_wait, rr_m0_rdv, rr_m1_wait, rr_m1_rdv;
  logic [31:0] rr_m0_rdata, rr_m1_rdata;
  logic [29:0] rr_s_address;
  logic [31:0] rr_s_writedata;
  logic [3:0]  rr_s_byteenable;
  logic [2:0]  rr_s_burstcount;
  logic        rr_s_write, rr_s_read;

  logic        fp_m0_wait, fp_m0_rdv, fp_m1_wait, fp_m1_rdv;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic [29:0] fp_s_address;
  logic [31:0] fp_s_writedata;
  logic [3:0]  fp_s_byteenable;
  logic [2:0]  fp_s_burstcount;
  logic        fp_s_write, fp_s_read;

  int tests;
  int fails;

  avm_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_address_i(m0_address), .m0_writedata_i(m0_writedata),
    .m0_byteenable_i(m0_byteenable), .m0_burstcount_i(m0_burstcount),
    .m0_write_i(m0_write), .m0_read_i(m0_read),
    .m0_waitrequest_o(rr_m0_wait), .m0_readdatavalid_o(rr_m0_rdv), .m0_readdata_o(rr_m0_rdata),
    .m1_address_i(m1_address), .m1_writedata_i(m1_writedata),
    .m1_byteenable_i(m1_byteenable), .m1_burstcount_i(m1_burstcount),
    .m1_write_i(m1_write), .m1_read_i(m1_read),
    .m1_waitrequest_o(rr_m1_wait), .m1_readdatavalid_o(rr_m1_rdv), .m1_readdata_o(rr_m1_rdata),
    .s_address_o(rr_s_address), .s_writedata_o(rr_s_writedata),
    .s_byteenable_o(rr_s_byteenable), .s_burstcount_o(rr_s_burstcount),
    .s_write_o(rr_s_write), .s_read_o(rr_s_read),
    .s_waitrequest_i(s_waitrequest), .s_readdatavalid_i(s_readdatavalid),
    .s_readdata_i(s_readdata)
  );

  avm_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_address_i(m0_address), .m0_writedata_i(m0_writedata),
    .m0_byteenable_i(m0_byteenable), .m0_burstcount_i(m0_burstcount),
    .m0_write_i(m0_write), .m0_read_i(m0_read),
    .m0_waitrequest_o(fp_m0_wait), .m0_readdatavalid_o(fp_m0_rdv), .m0_readdata_o(fp_m0_rdata),
    .m1_address_i(m1_address), .m1_writedata_i(m1_writedata),
    .m1_byteenable_i(m1_byteenable), .m1_burstcount_i(m1_burstcount),
    .m1_write_i(m1_write), .m1_read_i(m1_read),
    .m1_waitrequest_o(fp_m1_wait), .m1_readdatavalid_o(fp_m1_rdv), .m1_readdata_o(fp_m1_rdata),
    .s_address_o(fp_s_address), .s_writedata_o(fp_s_writedata),
    .s_byteenable_o(fp_s_byteenable), .s_burstcount_o(fp_s_burstcount),
    .s_write_o(fp_s_write), .s_read_o(fp_s_read),
    .s_waitrequest_i(s_waitrequest), .s_readdatavalid_i(s_readdatavalid),
    .s_readdata_i(s_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '0; m1_byteenable = '0; m0_burstcount = '0; m1_burstcount = '0;
    m0_write = 1'b0; m0_read = 1'b0; m1_write = 1'b0; m1_read = 1'b0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  // Leaves the bench just after a falling edge with reset released and both DUTs idle.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    m0_read = 1'b1; m0_address = 30'h155; m0_writedata = 32'h1111_2222;
    m0_byteenable = 4'hF; m0_burstcount = 3'd2;
    s_readdatavalid = 1'b1; s_readdata = 32'h1234_5678;
    @(negedge clk); #1;
    tests++; if (rr_s_read !== 1'b0) begin fails++; $display("FAIL rst_s_read: got %b expected 0", rr_s_read); end
    tests++; if (rr_s_write !== 1'b0) begin fails++; $display("FAIL rst_s_write: got %b expected 0", rr_s_write); end
    tests++; if (rr_s_address !== 30'h0) begin fails++; $display("FAIL rst_s_address: got %h expected 0", rr_s_address); end
    tests++; if (rr_s_writedata !== 32'h0) begin fails++; $display("FAIL rst_s_writedata: got %h expected 0", rr_s_writedata); end
    tests++; if (rr_s_byteenable !== 4'h0) begin fails++; $display("FAIL rst_s_be: got %h expected 0", rr_s_byteenable); end
    tests++; if (rr_s_burstcount !== 3'h0) begin fails++; $display("FAIL rst_s_bc: got %h expected 0", rr_s_burstcount); end
    tests++; if (rr_m0_wait !== 1'b1 || rr_m1_wait !== 1'b1) begin
      fails++; $display("FAIL rst_wait: got %b%b expected 11", rr_m0_wait, rr_m1_wait); end
    tests++; if (rr_m0_rdv !== 1'b0 || rr_m1_rdv !== 1'b0) begin
      fails++; $display("FAIL rst_rdv: got %b%b expected 00", rr_m0_rdv, rr_m1_rdv); end
    tests++; if ({fp_s_read, fp_s_write, fp_m0_rdv, fp_m1_rdv} !== 4'b0000) begin
      fails++; $display("FAIL rst_fp_strobes: got %b%b%b%b expected 0000",
                        fp_s_read, fp_s_write, fp_m0_rdv, fp_m1_rdv); end
    tests++; if ({fp_s_address, fp_s_writedata, fp_s_byteenable, fp_s_burstcount} !== '0) begin
      fails++; $display("FAIL rst_fp_bus: got %h %h expected 0 0", fp_s_address, fp_s_writedata); end
    tests++; if (fp_m0_wait !== 1'b1 || fp_m1_wait !== 1'b1) begin
      fails++; $display("FAIL rst_fp_wait: got %b%b expected 11", fp_m0_wait, fp_m1_wait); end
    tests++; if (fp_m0_rdata !== 32'h1234_5678 || fp_m1_rdata !== 32'h1234_5678) begin
      fails++; $display("FAIL rst_fp_rdata: got %h %h expected 12345678", fp_m0_rdata, fp_m1_rdata); end
    do_reset();
  endtask

  task automatic test_read_burst();
    logic [31:0] rd [4];
    rd[0] = 32'hAAAA_0001; rd[1] = 32'hBBBB_0002; rd[2] = 32'hCCCC_0003; rd[3] = 32'hDDDD_0004;
    do_reset();
    m0_address = 30'h400; m0_burstcount = 3'd4; m0_read = 1'b1;
    #1;
    tests++; if (rr_m0_wait !== 1'b1) begin fails++; $display("FAIL rd_idle_wait: got %b expected 1", rr_m0_wait); end
    @(negedge clk); #1;
    tests++; if (rr_s_read !== 1'b1 || rr_s_address !== 30'h400 || rr_s_burstcount !== 3'd4) begin
      fails++; $display("FAIL rd_grant_cmd: got read=%b addr=%h bc=%0d expected 1 400 4",
                        rr_s_read, rr_s_address, rr_s_burstcount); end
    tests++; if (rr_m0_wait !== 1'b0 || rr_m1_wait !== 1'b1) begin
      fails++; $display("FAIL rd_grant_wait: got %b%b expected 01", rr_m0_wait, rr_m1_wait); end
    @(negedge clk);
    m0_read = 1'b0;
    #1;
    tests++; if (rr_s_read !== 1'b0 || rr_m0_wait !== 1'b1) begin
      fails++; $display("FAIL rd_wait_state: got read=%b wait=%b expected 0 1", rr_s_read, rr_m0_wait); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      s_readdatavalid = 1'b1; s_readdata = rd[i];
      #1;
      tests++; if (rr_m0_rdv !== 1'b1 || rr_m0_rdata !== rd[i] || rr_m1_rdv !== 1'b0) begin
        fails++; $display("FAIL rd_beat%0d: got v0=%b d=%h v1=%b expected 1 %h 0",
                          i, rr_m0_rdv, rr_m0_rdata, rr_m1_rdv, rd[i]); end
      @(negedge clk);
    end
    s_readdatavalid = 1'b1; s_readdata = 32'hDEAD_BEEF;
    #1;
    tests++; if (rr_m0_rdv !== 1'b0) begin fails++; $display("FAIL rd_after_last: got %b expected 0", rr_m0_rdv); end
    s_readdatavalid = 1'b0;
  endtask

  task automatic test_contention();
    int exp_cyc [6];
    logic [31:0] exp_dat [6];
    int m0_txn, m0_beat, m1_txn, m1_beat, n_acc;
    exp_cyc = '{1, 2, 4, 5, 7, 8};
    exp_dat = '{32'hA000_0000, 32'hA000_0001, 32'hB000_0000, 32'hB000_0001,
                32'hA000_0010, 32'hA000_0011};
    m0_txn = 0; m0_beat = 0; m1_txn = 0; m1_beat = 0; n_acc = 0;
    do_reset();
    m0_address = 30'h10; m1_address = 30'h20; m0_burstcount = 3'd2; m1_burstcount = 3'd2;
    m0_byteenable = 4'hF; m1_byteenable = 4'h3;
    for (int c = 0; c < 14; c++) begin
      m0_write = (m0_txn < 2);
      m1_write = (m1_txn < 2);
      m0_writedata = 32'hA000_0000 + 32'(m0_txn * 16 + m0_beat);
      m1_writedata = 32'hB000_0000 + 32'(m1_txn * 16 + m1_beat);
      #1;
      if (rr_s_write && !s_waitrequest) begin
        if (n_acc < 6) begin
          tests++; if (c !== exp_cyc[n_acc] || rr_s_writedata !== exp_dat[n_acc]) begin
            fails++; $display("FAIL cont_acc%0d: got cyc=%0d data=%h expected cyc=%0d data=%h",
                              n_acc, c, rr_s_writedata, exp_cyc[n_acc], exp_dat[n_acc]); end
          tests++; if (rr_s_byteenable !== (exp_dat[n_acc][28] ? 4'h3 : 4'hF)) begin
            fails++; $display("FAIL cont_be%0d: got %h", n_acc, rr_s_byteenable); end
          tests++; if ((rr_m0_wait | rr_m1_wait) !== 1'b1) begin
            fails++; $display("FAIL cont_excl%0d: got both waits low expected one high", n_acc); end
        end
        n_acc++;
      end
      if (m0_write && !rr_m0_wait) begin
        m0_beat++; if (m0_beat == 2) begin m0_beat = 0; m0_txn++; end
      end
      if (m1_write && !rr_m1_wait) begin
        m1_beat++; if (m1_beat == 2) begin m1_beat = 0; m1_txn++; end
      end
      @(negedge clk);
    end
    tests++; if (n_acc !== 8) begin fails++; $display("FAIL cont_total: got %0d expected 8", n_acc); end
    m0_write = 1'b0; m1_write = 1'b0;
  endtask

  task automatic test_fixed_priority();
    int n_acc;
    n_acc = 0;
    do_reset();
    m0_burstcount = 3'd1; m1_burstcount = 3'd1;
    m0_writedata = 32'h0000_C0DE; m1_writedata = 32'hBAD0_0001;
    m0_write = 1'b1; m1_write = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      tests++; if (fp_m1_wait !== 1'b1) begin
        fails++; $display("FAIL fp_m1_wait c%0d: got %b expected 1", c, fp_m1_wait); end
      if (fp_s_write && !s_waitrequest) begin
        n_acc++;
        tests++; if (fp_s_writedata !== 32'h0000_C0DE) begin
          fails++; $display("FAIL fp_data c%0d: got %h expected 0000c0de", c, fp_s_writedata); end
      end
      @(negedge clk);
    end
    tests++; if (n_acc !== 6) begin fails++; $display("FAIL fp_total: got %0d expected 6", n_acc); end
    m0_write = 1'b0; m1_write = 1'b0;
  endtask

  task automatic test_wait_burst();
    logic wait_tab [8];
    int exp_cyc [3];
    int beat, n_acc;
    wait_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_cyc = '{1, 4, 5};
    beat = 0; n_acc = 0;
    do_reset();
    m0_address = 30'h200; m0_burstcount = 3'd3; m0_byteenable = 4'hF;
    for (int c = 0; c < 8; c++) begin
      s_waitrequest = wait_tab[c];
      m0_write = (beat < 3);
      m0_writedata = 32'hD000_0000 + 32'(beat);
      #1;
      if (rr_s_write && !s_waitrequest) begin
        if (n_acc < 3) begin
          tests++; if (c !== exp_cyc[n_acc] || rr_s_writedata !== 32'hD000_0000 + 32'(n_acc)) begin
            fails++; $display("FAIL wb_acc%0d: got cyc=%0d data=%h expected cyc=%0d", n_acc, c,
                              rr_s_writedata, exp_cyc[n_acc]); end
        end
        n_acc++;
      end
      if (c == 2 || c == 3) begin
        tests++; if (rr_s_write !== 1'b1 || rr_m0_wait !== 1'b1 || rr_s_writedata !== 32'hD000_0001) begin
          fails++; $display("FAIL wb_stall c%0d: got w=%b wait=%b d=%h expected 1 1 d0000001",
                            c, rr_s_write, rr_m0_wait, rr_s_writedata); end
      end
      if (c == 6) begin
        tests++; if (rr_s_write !== 1'b0 || rr_m0_wait !== 1'b1) begin
          fails++; $display("FAIL wb_idle: got w=%b wait=%b expected 0 1", rr_s_write, rr_m0_wait); end
      end
      if (m0_write && !rr_m0_wait) beat++;
      @(negedge clk);
    end
    tests++; if (n_acc !== 3) begin fails++; $display("FAIL wb_total: got %0d expected 3", n_acc); end
    m0_write = 1'b0; s_waitrequest = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m0_address = 30'h400; m0_burstcount = 3'd4; m0_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m0_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_readdatavalid = 1'b1; s_readdata = 32'h0BEA_0000 + 32'(i);
      #1;
      tests++; if (rr_m0_rdv !== 1'b1) begin fails++; $display("FAIL rm_beat%0d: got %b expected 1", i, rr_m0_rdv); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    tests++; if (rr_m0_rdv !== 1'b0 || rr_s_read !== 1'b0 || rr_m0_wait !== 1'b1 || rr_s_burstcount !== 3'd0) begin
      fails++; $display("FAIL rm_in_reset: got rdv=%b read=%b wait=%b bc=%0d expected 0 0 1 0",
                        rr_m0_rdv, rr_s_read, rr_m0_wait, rr_s_burstcount); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (rr_m0_rdv !== 1'b0 || rr_m1_rdv !== 1'b0) begin
        fails++; $display("FAIL rm_late%0d: got %b%b expected 00", i, rr_m0_rdv, rr_m1_rdv); end
      @(negedge clk);
    end
    s_readdatavalid = 1'b0;
  endtask

  task automatic test_burst0();
    do_reset();
    m1_address = 30'h77; m1_burstcount = 3'd0; m1_read = 1'b1;
    @(negedge clk); #1;
    tests++; if (rr_s_read !== 1'b1 || rr_s_address !== 30'h77 || rr_m1_wait !== 1'b0 || rr_m0_wait !== 1'b1) begin
      fails++; $display("FAIL b0_grant: got read=%b addr=%h w1=%b w0=%b expected 1 77 0 1",
                        rr_s_read, rr_s_address, rr_m1_wait, rr_m0_wait); end
    @(negedge clk);
    m1_read = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 32'h5A5A_5A5A;
    #1;
    tests++; if (rr_m1_rdv !== 1'b1 || rr_m1_rdata !== 32'h5A5A_5A5A || rr_m0_rdv !== 1'b0) begin
      fails++; $display("FAIL b0_beat: got v1=%b d=%h v0=%b expected 1 5a5a5a5a 0",
                        rr_m1_rdv, rr_m1_rdata, rr_m0_rdv); end
    tests++; if (rr_m0_rdata !== 32'h5A5A_5A5A) begin
      fails++; $display("FAIL b0_m0_rdata: got %h expected 5a5a5a5a", rr_m0_rdata); end
    @(negedge clk); #1;
    tests++; if (rr_m1_rdv !== 1'b0) begin fails++; $display("FAIL b0_done: got %b expected 0", rr_m1_rdv); end
    s_readdatavalid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_read_burst();
    test_contention();
    test_fixed_priority();
    test_wait_burst();
    test_reset_mid_read();
    test_burst0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
